// File: rtl/loader_pkg.sv
// Shared types and default geometry for the instruction-memory program loader.
package loader_pkg;

    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MEM_DEPTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_FILL,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Loads a LEN/data/CSUM framed byte stream into the instruction memory and holds the core
// in reset until the image verifies. Define LOADER_ZERO_FILL_EN to zero the unused tail.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // One extra bit so the count and length can represent MEM_DEPTH itself.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              transfer_c;
    logic              len_ok_c;
    logic              csum_ok_c;

    // A start in the same cycle as a handshake wins; the byte is left for a retry.
    assign transfer_c = in_valid & in_ready_q & ~start;
    assign len_ok_c   = (in_data != '0) && (32'(in_data) <= MEM_DEPTH);
    assign csum_ok_c  = (DATA_W'(sum_q + in_data) == '0);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;

        if (start) begin
            state_d = ST_LEN;
            sum_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (transfer_c) begin
                        len_d   = CNT_W'(in_data);
                        state_d = len_ok_c ? ST_DATA : ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (transfer_c) begin
                        mem_we_d    = 1'b1;
                        mem_adr_d   = count_q[ADDR_W-1:0];
                        mem_wdata_d = in_data;
                        sum_d       = sum_q + in_data;
                        count_d     = count_q + CNT_W'(1);
                        if (count_q + CNT_W'(1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (transfer_c) begin
`ifdef LOADER_ZERO_FILL_EN
                        if (!csum_ok_c) begin
                            state_d = ST_ERR;
                        end else if (len_q == CNT_W'(MEM_DEPTH)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FILL;
                        end
`else
                        state_d = csum_ok_c ? ST_DONE : ST_ERR;
`endif
                    end
                end
`ifdef LOADER_ZERO_FILL_EN
                // Count continues from N and walks the tail up to the last word.
                ST_FILL: begin
                    mem_we_d    = 1'b1;
                    mem_adr_d   = count_q[ADDR_W-1:0];
                    mem_wdata_d = '0;
                    count_d     = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(MEM_DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
`endif
                default: begin
                end
            endcase
        end

        // Status outputs are registered copies of the decoded next state.
        in_ready_d = ~start && ((state_d == ST_LEN) || (state_d == ST_DATA) ||
                                (state_d == ST_CSUM));
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        cpu_hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level model.
module tb_program_loader;

    localparam int unsigned DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_adr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  adr;
        logic [7:0]  data;
    } wr_t;

    int unsigned cyc = 0;
    wr_t         wr_q[$];
    int unsigned checks = 0;
    int unsigned passed = 0;
    bit          gaps = 1'b0;

    logic [7:0]  frame_data[$];
    int unsigned acc_cyc[$];
    int unsigned csum_acc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back({32'(cyc), mem_adr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte and returns the cycle index at which it is written, if it is data.
    task automatic send(input logic [7:0] b, output int unsigned acc);
        int unsigned n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        acc = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 50) begin
            if (in_ready === 1'b1) begin
                acc = cyc + 1;
                ok  = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!ok) check("handshake_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_end();
        int unsigned n;
        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    task automatic run_frame(input logic [7:0] len, input logic [7:0] csum, input string tag);
        int unsigned a;
        int unsigned sum;
        int unsigned n_exp;
        int          bad_idx;
        bit          bad_len;
        bit          good;
        wr_t         w;
        wr_q.delete();
        acc_cyc.delete();
        pulse_start();
        send(len, a);
        bad_len = (len == 0) || (int'(len) > DEPTH);
        sum = 0;
        if (!bad_len) begin
            foreach (frame_data[i]) begin
                send(frame_data[i], a);
                acc_cyc.push_back(a);
                sum += frame_data[i];
            end
            send(csum, csum_acc);
        end
        good = !bad_len && (((sum + csum) % 256) == 0);
        wait_end();
        check({tag, "_done"},     32'(done),     32'(good));
        check({tag, "_err"},      32'(err),      32'(!good));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!good));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));

        n_exp = bad_len ? 0 : int'(len);
`ifdef LOADER_ZERO_FILL_EN
        if (good) n_exp = DEPTH;
`endif
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n_exp));
        bad_idx = -1;
        for (int i = 0; i < int'(n_exp) && i < wr_q.size(); i++) begin
            if (i < int'(len)) w = {32'(acc_cyc[i]), 5'(i), frame_data[i]};
            else               w = {32'(csum_acc + 1 + (i - int'(len))), 5'(i), 8'h00};
            if (wr_q[i] !== w && bad_idx < 0) bad_idx = i;
        end
        check({tag, "_writes"}, 32'(bad_idx), 32'(-1));

        // Bytes offered after the frame has ended must be ignored.
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_idle_nowrite"}, 32'(wr_q.size()), 32'(n_exp));
        check({tag, "_idle_done"},    32'(done),        32'(good));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'(0));
        check({tag, "_mem_we"},    32'(mem_we),    32'(0));
        check({tag, "_mem_adr"},   32'(mem_adr),   32'(0));
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'(1));
        check({tag, "_done"},      32'(done),      32'(0));
        check({tag, "_err"},       32'(err),       32'(0));
    endtask

    initial begin
        int unsigned a;
        int unsigned s;
        logic [7:0]  len;
        logic [7:0]  cs;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_reset("idle");
        check("idle_nowrite", 32'(wr_q.size()), 32'(0));

        frame_data = '{8'h11, 8'h22, 8'h33};
        run_frame(8'd3, 8'h9A, "t1_good");
        run_frame(8'd3, 8'h00, "t2_badsum");

        frame_data.delete();
        run_frame(8'd0,  8'h00, "t3_len0");
        run_frame(8'd33, 8'h00, "t3_len33");

        gaps = 1'b1;
        frame_data.delete();
        s = 0;
        for (int i = 0; i < 32; i++) begin
            frame_data.push_back(8'($urandom));
            s += frame_data[i];
        end
        run_frame(8'd32, 8'(256 - (s % 256)), "t4_full");

        // Restart mid-DATA with a byte offered in the same cycle as start.
        gaps = 1'b0;
        wr_q.delete();
        pulse_start();
        send(8'd4, a);
        send(8'h10, a);
        send(8'h20, a);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check("t5_ready_after_start", 32'(in_ready), 32'(0));
        repeat (2) @(negedge clk);
        #1;
        check("t5_no_ee_write", 32'(wr_q.size()), 32'(2));
        check("t5_in_len", 32'(in_ready), 32'(1));
        wr_q.delete();
        send(8'd1, a);
        send(8'h5A, a);
        send(8'hA6, a);
        wait_end();
        check("t5_done", 32'(done), 32'(1));
`ifdef LOADER_ZERO_FILL_EN
        check("t5_nwrites", 32'(wr_q.size()), 32'(DEPTH));
`else
        check("t5_nwrites", 32'(wr_q.size()), 32'(1));
`endif
        if (wr_q.size() > 0) check("t5_write0", 32'({wr_q[0].adr, wr_q[0].data}), 32'({5'd0, 8'h5A}));
        else                 check("t5_write0", 32'(0), 32'({5'd0, 8'h5A}));

        // Synchronous reset in the middle of DATA.
        pulse_start();
        send(8'd5, a);
        send(8'h01, a);
        send(8'h02, a);
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check_reset("t5_rst");

        frame_data = '{8'h01, 8'h02};
        run_frame(8'd2, 8'hFD, "t6_two");

        // Random frames, some with a corrupted checksum or illegal length.
        gaps = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame_data.delete();
            len = 8'($urandom_range(1, 32));
            s = 0;
            for (int i = 0; i < int'(len); i++) begin
                frame_data.push_back(8'($urandom));
                s += frame_data[i];
            end
            cs = 8'(256 - (s % 256));
            if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
            if (f == 5) len = 8'($urandom_range(33, 255));
            run_frame(len, cs, $sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

endmodule
